// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//
// Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions in
// the execute stage. One operand pair is accepted per start request. The
// divider then produces one quotient bit per cycle and returns
// {remainder, quotient} in HI/LO layout (HI = remainder, LO = quotient).
//
// Ports
//   clk        in   1         clock, all state changes on the rising edge
//   rst        in   1         synchronous reset, active-high
//   start_i    in   1         division request, only looked at in IDLE
//   signed_i   in   1         1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  in   WIDTH     dividend, captured when the request is taken
//   opdata2_i  in   WIDTH     divisor, captured when the request is taken
//   annul_i    in   1         pipeline flush: drop the current operation
//   result_o   out  2*WIDTH   {remainder, quotient}
//   ready_o    out  1         one-cycle pulse, result_o is valid with it
//   busy_o     out  1         high whenever the unit is not idle
//
// Timing (WIDTH = 32): request taken in cycle 0, iteration in cycles 1..32,
// ready_o in cycle 33. A zero divisor gives ready_o in cycle 2.
// ----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Count value seen in the cycle that performs the final iteration.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------

  // Two's complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Magnitude of an operand. In unsigned mode the operand is already a
  // magnitude. The most negative signed value maps onto itself, and it is
  // then read as an unsigned number, which is its true magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic             sign_en,
                                               input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] mag;
    if (sign_en && v[WIDTH-1]) begin
      mag = twos_neg(v);
    end else begin
      mag = v;
    end
    return mag;
  endfunction

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  // Partial remainder {upper part, dividend/quotient}, 2*WIDTH+1 bits
  logic [2*WIDTH:0]   pr_q,      pr_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0] result_q,  result_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;

  // --------------------------------------------------------------------------
  // One restoring iteration
  // --------------------------------------------------------------------------
  logic [2*WIDTH+1:0] sh_s;      // partial remainder shifted left by one
  logic [WIDTH+1:0]   diff_s;    // trial difference over the upper part
  logic               fits_s;    // divisor fits, so the quotient bit is 1
  logic [2*WIDTH:0]   step_s;    // partial remainder after this iteration
  logic [WIDTH-1:0]   quo_fix_s; // final quotient with its sign applied
  logic [WIDTH-1:0]   rem_fix_s; // final remainder with its sign applied

  // Shift, trial-subtract, and keep or restore the partial remainder.
  always_comb begin
    sh_s   = {pr_q, 1'b0};
    diff_s = sh_s[2*WIDTH+1:WIDTH] - {2'b00, divisor_q};
    fits_s = ~diff_s[WIDTH+1];
    if (fits_s) begin
      // Upper part becomes the difference. The free low bit takes a 1.
      step_s = {diff_s[WIDTH:0], sh_s[WIDTH-1:1], 1'b1};
    end else begin
      // Restore: keep the shifted value. Its low bit is already 0.
      step_s = sh_s[2*WIDTH:0];
    end
  end

  // Sign fixup of the final iteration's result. It is registered on the
  // edge into END, so result_o is already valid in the END cycle.
  always_comb begin
    if (quo_neg_q) begin
      quo_fix_s = twos_neg(step_s[WIDTH-1:0]);
    end else begin
      quo_fix_s = step_s[WIDTH-1:0];
    end
    if (rem_neg_q) begin
      rem_fix_s = twos_neg(step_s[2*WIDTH-1:WIDTH]);
    end else begin
      rem_fix_s = step_s[2*WIDTH-1:WIDTH];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and register updates
  // --------------------------------------------------------------------------

  // Next-state and next-value logic for the control FSM and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        // A request that arrives together with a flush is dropped.
        if (start_i && !annul_i) begin
          divisor_d = abs_mag(signed_i, opdata2_i);
          pr_d      = {{(WIDTH + 1){1'b0}}, abs_mag(signed_i, opdata1_i)};
          cnt_d     = {CNT_W{1'b0}};
          quo_neg_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rem_neg_d = signed_i & opdata1_i[WIDTH-1];
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DIVZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          // No trap. Quotient and remainder both read as zero.
          pr_d     = {(2 * WIDTH + 1){1'b0}};
          result_d = {(2 * WIDTH){1'b0}};
          state_d  = S_END;
        end
      end

      S_ON: begin
        if (annul_i) begin
          // A flush wins over the last iteration. result_q stays as it is.
          state_d = S_IDLE;
        end else begin
          pr_d  = step_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = {rem_fix_s, quo_fix_s};
            state_d  = S_END;
          end else begin
            state_d = S_ON;
          end
        end
      end

      S_END: begin
        // The result is presented this cycle. Both paths go back to idle.
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flags are registered and follow the state being entered.
    ready_d = (state_d == S_END);
    busy_d  = (state_d != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      pr_q      <= {(2 * WIDTH + 1){1'b0}};
      divisor_q <= {WIDTH{1'b0}};
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= {(2 * WIDTH){1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pr_q      <= pr_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit (WIDTH = 32). Expected results come from
// plain integer division in a reference function. Directed cases use the
// known constant results. The bench drives inputs and samples outputs on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  // Reference: MIPS DIV/DIVU semantics with truncating division.
  // A zero divisor yields zero.
  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (!sg) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call this on a falling edge. The current cycle becomes cycle 0 of the
  // request. The task returns on the falling edge of the first idle cycle
  // after ready, so the next request can follow back-to-back.
  task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit hold_start, input string tag);
    int cyc;
    int busy_bad;
    int exp_lat;
    exp_lat  = (b == 32'd0) ? 2 : 33;
    busy_bad = 0;
    chk({tag, "_busy_c0"}, 64'(busy_o), 64'd0);
    start_i   = 1'b1;
    signed_i  = sg;
    opdata1_i = a;
    opdata2_i = b;
    annul_i   = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (ready_o !== 1'b1 && cyc < 45) begin
      if (busy_o !== 1'b1) busy_bad++;
      if (hold_start) begin
        start_i   = 1'b1;
        signed_i  = 1'($urandom_range(0, 1));
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk({tag, "_ready"},   64'(ready_o), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_on"}, 64'(busy_bad), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd1);
    chk({tag, "_result"},  result_o, exp);
    last_res = exp;
    @(negedge clk);
    chk({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
    chk({tag, "_busy_idle"},   64'(busy_o), 64'd0);
    chk({tag, "_result_hold"}, result_o, last_res);
  endtask

  initial begin
    int          ready_seen;
    bit          sg;
    logic [31:0] a, b;

    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    annul_i   = 1'b0;
    last_res  = 64'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready",  64'(ready_o), 64'd0);
    chk("reset_busy",   64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with known results
    do_div(1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 1'b0, "divu_7_2");
    do_div(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_m7_2");
    do_div(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0, "div_7_m2");
    do_div(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0, "divu_max_1");
    do_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0, "div_min_m1");
    do_div(1'b0, 32'd5,          32'd0,          64'd0,                 1'b0, "divu_zero");
    do_div(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, "divu_100_7");
    do_div(1'b1, 32'hFFFFFFF0,   32'd0,          64'd0,                 1'b0, "div_zero");

    // Flush at cycle 10: back to idle next cycle, no ready, result kept
    do_div(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 1'b0, "pre_annul");
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd11;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy",   64'(busy_o), 64'd0);
    chk("annul_ready",  64'(ready_o), 64'd0);
    chk("annul_result", result_o, last_res);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o === 1'b1) ready_seen++;
      @(negedge clk);
    end
    chk("annul_no_ready",  64'(ready_seen), 64'd0);
    chk("annul_result_kept", result_o, last_res);
    do_div(1'b0, 32'd12345, 32'd11, 64'h00000003_00000462, 1'b0, "post_annul");

    // A request together with a flush in idle is dropped
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    chk("start_annul_busy", 64'(busy_o), 64'd0);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o === 1'b1) ready_seen++;
      @(negedge clk);
    end
    chk("start_annul_no_ready", 64'(ready_seen), 64'd0);

    // start_i held with changing operands while busy: original result
    do_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b1, "hold_start");

    // Reset during an operation at cycle 15
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hDEADBEEF;
    opdata2_i = 32'd17;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_ready",  64'(ready_o), 64'd0);
    chk("midrst_busy",   64'(busy_o), 64'd0);
    rst      = 1'b0;
    last_res = 64'd0;
    @(negedge clk);
    chk("midrst_idle_busy", 64'(busy_o), 64'd0);
    do_div(1'b1, 32'hFFFFFF9C, 32'd7, ref_div(1'b1, 32'hFFFFFF9C, 32'd7), 1'b0, "post_rst");

    // Random operands against the reference model
    for (int n = 0; n < 24; n++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_div(sg, a, b, ref_div(sg, a, b), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
